alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: operand/issue controller for the 8-bit ALU; owns an 8-entry register file.
// Latency: 3 cycles per instruction (IDLE accept -> ISSUE -> DONE), writeback at end of ISSUE.
// Backpressure: instr_ready/ld_ready low outside IDLE; a load in IDLE wins and holds off instr_ready.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   instr_valid/ready - instruction handshake; instr = {selop,shamt,enaf,rd,rs1,rs2,wb_en}
//   ld_valid/ready    - register load side port (ld_addr, ld_data)
//   busA/busB/selop/shamt/enaf - registered ALU controls; busC - ALU result back in
//   res_valid/res_data - one-cycle result strobe and held result; busy - not IDLE
module alu_issue_ctrl #(
  parameter int MAX_WIDTH = 8,
  parameter bit ZERO_REG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [15:0]          instr,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [2:0]           ld_addr,
  input  logic [MAX_WIDTH-1:0] ld_data,
  output logic [MAX_WIDTH-1:0] busA,
  output logic [MAX_WIDTH-1:0] busB,
  output logic [2:0]           selop,
  output logic [1:0]           shamt,
  output logic                 enaf,
  input  logic [MAX_WIDTH-1:0] busC,
  output logic                 res_valid,
  output logic [MAX_WIDTH-1:0] res_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MAX_WIDTH-1:0] regs [8];
  logic [2:0]           rd_q;
  logic                 wb_q;
  logic                 accept;
  logic                 ld_fire;
  logic                 wb_fire;

  // Instruction fields
  logic [2:0] i_selop;
  logic [1:0] i_shamt;
  logic       i_enaf;
  logic [2:0] i_rd;
  logic [2:0] i_rs1;
  logic [2:0] i_rs2;
  logic       i_wb;

  assign i_selop = instr[15:13];
  assign i_shamt = instr[12:11];
  assign i_enaf  = instr[10];
  assign i_rd    = instr[9:7];
  assign i_rs1   = instr[6:4];
  assign i_rs2   = instr[3:1];
  assign i_wb    = instr[0];

  // With ZERO_REG set, r0 always reads as zero regardless of array contents.
  logic [MAX_WIDTH-1:0] opa, opb;
  assign opa = (ZERO_REG && (i_rs1 == 3'd0)) ? '0 : regs[i_rs1];
  assign opb = (ZERO_REG && (i_rs2 == 3'd0)) ? '0 : regs[i_rs2];

  assign ld_fire = (state == IDLE) && ld_valid;
  assign wb_fire = (state == ISSUE) && wb_q && !(ZERO_REG && (rd_q == 3'd0));

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        ld_ready    = 1'b1;
        // A pending load takes the cycle; the instruction waits.
        instr_ready = !ld_valid;
        if (instr_valid && !ld_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Register file: loads only in IDLE, writeback only at end of ISSUE, never both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (ld_fire) begin
      if (!(ZERO_REG && (ld_addr == 3'd0))) regs[ld_addr] <= ld_data;
    end else if (wb_fire) begin
      regs[rd_q] <= busC;
    end
  end

  // ALU-facing controls are captured at accept and held until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busA     <= '0;
      busB     <= '0;
      selop    <= '0;
      shamt    <= '0;
      enaf     <= 1'b0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      res_data <= '0;
    end else begin
      if (accept) begin
        busA  <= opa;
        busB  <= opb;
        selop <= i_selop;
        shamt <= i_shamt;
        enaf  <= i_enaf;
        rd_q  <= i_rd;
        wb_q  <= i_wb;
      end
      if (state == ISSUE) begin
        res_data <= busC;
        // Flags update exactly once per instruction.
        enaf     <= 1'b0;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        force_c;

  logic        instr_ready, ld_ready, enaf, res_valid, busy;
  logic [7:0]  busA, busB, busC, res_data;
  logic [2:0]  selop;
  logic [1:0]  shamt;

  logic        instr_ready0, ld_ready0, enaf0, res_valid0, busy0;
  logic [7:0]  busA0, busB0, busC0, res_data0;
  logic [2:0]  selop0;
  logic [1:0]  shamt0;

  int n_chk;
  int n_fail;

  // Stand-in ALU: plain arithmetic per operation code.
  function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [1:0] sh,
                                         input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << sh;
      3'd6:    return a >> sh;
      default: return a;
    endcase
  endfunction

  assign busC  = force_c ? 8'hAA : alu_ref(selop, shamt, busA, busB);
  assign busC0 = force_c ? 8'hAA : alu_ref(selop0, shamt0, busA0, busB0);

  alu_issue_ctrl #(.MAX_WIDTH(8), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .busA(busA), .busB(busB), .selop(selop), .shamt(shamt),
    .enaf(enaf), .busC(busC), .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  alu_issue_ctrl #(.MAX_WIDTH(8), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready0),
    .instr(instr), .ld_valid(ld_valid), .ld_ready(ld_ready0), .ld_addr(ld_addr),
    .ld_data(ld_data), .busA(busA0), .busB(busB0), .selop(selop0), .shamt(shamt0),
    .enaf(enaf0), .busC(busC0), .res_valid(res_valid0), .res_data(res_data0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (actual: running, required: finished)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] sel, input logic [1:0] sh, input logic en,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2, input logic wb);
    return {sel, sh, en, rd, rs1, rs2, wb};
  endfunction

  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Offers one instruction in IDLE; samples ISSUE values, then DONE values.
  task automatic exec(input logic [15:0] ins,
                      output logic [7:0] a, output logic [7:0] b, output logic [7:0] a0,
                      output logic en_iss, output logic en_done,
                      output logic rv, output logic [7:0] res);
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    a      = busA;
    b      = busB;
    a0     = busA0;
    en_iss = enaf;
    @(negedge clk);
    rv      = res_valid;
    res     = res_data;
    en_done = enaf;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [1:0] sh;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [9];
  logic [7:0] model [8];

  initial begin
    logic [7:0] a, b, a0, res;
    logic       ei, ed, rv;
    int         lowc;

    vt[0] = '{3'd0, 2'd0, 8'h05, 8'h03, 8'h08};
    vt[1] = '{3'd1, 2'd0, 8'h05, 8'h03, 8'h02};
    vt[2] = '{3'd2, 2'd0, 8'hF0, 8'h3C, 8'h30};
    vt[3] = '{3'd3, 2'd0, 8'hF0, 8'h0F, 8'hFF};
    vt[4] = '{3'd4, 2'd0, 8'hAA, 8'hFF, 8'h55};
    vt[5] = '{3'd5, 2'd2, 8'h03, 8'h00, 8'h0C};
    vt[6] = '{3'd6, 2'd3, 8'h80, 8'h00, 8'h10};
    vt[7] = '{3'd7, 2'd0, 8'h5A, 8'h00, 8'h5A};
    vt[8] = '{3'd0, 2'd0, 8'hFF, 8'h01, 8'h00};

    n_chk = 0; n_fail = 0;
    rst = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; force_c = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busA", busA, 0);
    chk("rst_busB", busB, 0);
    chk("rst_selop", selop, 0);
    chk("rst_shamt", shamt, 0);
    chk("rst_enaf", enaf, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    for (int r = 0; r < 8; r++) begin
      exec(mk(3'd7, 2'd0, 1'b0, 3'd0, r[2:0], 3'd0, 1'b0), a, b, a0, ei, ed, rv, res);
      chk($sformatf("rst_r%0d", r), a, 0);
    end

    // Table-driven operations via r1/r2 -> r5
    for (int i = 0; i < 9; i++) begin
      do_load(3'd1, vt[i].a);
      do_load(3'd2, vt[i].b);
      exec(mk(vt[i].sel, vt[i].sh, 1'b0, 3'd5, 3'd1, 3'd2, 1'b1), a, b, a0, ei, ed, rv, res);
      chk($sformatf("vec%0d_busA", i), a, vt[i].a);
      chk($sformatf("vec%0d_busB", i), b, vt[i].b);
      chk($sformatf("vec%0d_res_valid", i), rv, 1);
      chk($sformatf("vec%0d_res_data", i), res, vt[i].exp);
    end

    // Load then add with flags
    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    exec(mk(3'd0, 2'd0, 1'b1, 3'd3, 3'd1, 3'd2, 1'b1), a, b, a0, ei, ed, rv, res);
    chk("add_busA", a, 8'h05);
    chk("add_busB", b, 8'h03);
    chk("add_enaf_issue", ei, 1);
    chk("add_enaf_done", ed, 0);
    chk("add_res_valid", rv, 1);
    chk("add_res_data", res, 8'h08);
    chk("add_ready_done", instr_ready, 0);
    chk("add_ldready_done", ld_ready, 0);
    @(negedge clk);
    chk("add_res_valid_idle", res_valid, 0);
    chk("add_res_hold", res_data, 8'h08);
    exec(mk(3'd7, 2'd0, 1'b0, 3'd0, 3'd3, 3'd0, 1'b0), a, b, a0, ei, ed, rv, res);
    chk("add_r3_read", a, 8'h08);

    // Writes to r0
    force_c = 1'b1;
    exec(mk(3'd0, 2'd0, 1'b0, 3'd0, 3'd1, 3'd2, 1'b1), a, b, a0, ei, ed, rv, res);
    force_c = 1'b0;
    chk("zr_res_data", res, 8'hAA);
    exec(mk(3'd7, 2'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0), a, b, a0, ei, ed, rv, res);
    chk("zr_r0_zero_reg1", a, 8'h00);
    chk("zr_r0_zero_reg0", a0, 8'hAA);

    // Load/instruction collision
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 8'h77;
    instr = mk(3'd7, 2'd0, 1'b0, 3'd0, 3'd6, 3'd6, 1'b0); instr_valid = 1'b1;
    #1;
    chk("col_instr_ready", instr_ready, 0);
    chk("col_ld_ready", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("col_not_accepted", busy, 0);
    #1;
    chk("col_ready_after", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("col_busy", busy, 1);
    chk("col_busA", busA, 8'h77);
    chk("col_busB", busB, 8'h77);
    repeat (2) @(negedge clk);

    // Back-to-back dependency through r4
    do_load(3'd1, 8'h10);
    @(negedge clk);
    instr = mk(3'd7, 2'd0, 1'b0, 3'd4, 3'd1, 3'd0, 1'b1); instr_valid = 1'b1;
    @(negedge clk);
    instr = mk(3'd7, 2'd0, 1'b0, 3'd0, 3'd4, 3'd0, 1'b0);
    lowc = 0;
    while (lowc < 10 && !instr_ready) begin
      lowc++;
      @(negedge clk);
    end
    chk("b2b_ready_low_cycles", lowc, 2);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_busA", busA, 8'h10);
    repeat (2) @(negedge clk);

    // Reset during ISSUE
    do_load(3'd2, 8'h33);
    @(negedge clk);
    instr = mk(3'd7, 2'd0, 1'b1, 3'd7, 3'd2, 3'd0, 1'b1); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid_enaf_before", enaf, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_enaf_async", enaf, 0);
    chk("mid_busy_async", busy, 0);
    chk("mid_res_valid_async", res_valid, 0);
    @(negedge clk);
    chk("mid_res_valid_held", res_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_res_valid_after", res_valid, 0);
    chk("mid_res_data", res_data, 0);
    exec(mk(3'd7, 2'd0, 1'b0, 3'd0, 3'd7, 3'd2, 1'b0), a, b, a0, ei, ed, rv, res);
    chk("mid_r7", a, 0);
    chk("mid_r2", b, 0);

    // Randomized traffic against the register-file model
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [2:0] la;
        logic [7:0] ldv;
        la  = 3'($urandom_range(0, 7));
        ldv = 8'($urandom);
        do_load(la, ldv);
        if (la != 3'd0) model[la] = ldv;
      end else begin
        logic [15:0] ins;
        logic [7:0]  ea, eb, er;
        ins = 16'($urandom);
        ea  = model[ins[6:4]];
        eb  = model[ins[3:1]];
        er  = alu_ref(ins[15:13], ins[12:11], ea, eb);
        exec(ins, a, b, a0, ei, ed, rv, res);
        chk($sformatf("rnd%0d_busA", it), a, ea);
        chk($sformatf("rnd%0d_busB", it), b, eb);
        chk($sformatf("rnd%0d_enaf", it), ei, ins[10]);
        chk($sformatf("rnd%0d_res_valid", it), rv, 1);
        chk($sformatf("rnd%0d_res_data", it), res, er);
        if (ins[0] && ins[9:7] != 3'd0) model[ins[9:7]] = er;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
